// File: rtl/serial_bcd_add_ctrl_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package serial_bcd_add_ctrl_pkg;

  localparam int unsigned BCD_MAX_DIGIT = 9;
  localparam int unsigned BCD_RADIX     = 10;
  localparam int unsigned DIGIT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder with decimal carry and invalid-digit flag.
module bcd_digit_adder
  import serial_bcd_add_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               invalid
);

  logic [DIGIT_W:0] raw;

  always_comb begin
    raw     = (DIGIT_W+1)'(a) + (DIGIT_W+1)'(b) + (DIGIT_W+1)'(ci);
    s       = raw[DIGIT_W-1:0];
    co      = 1'b0;
    // Non-BCD inputs still go through the same correction path.
    if (raw > (DIGIT_W+1)'(BCD_MAX_DIGIT)) begin
      s  = DIGIT_W'(raw - (DIGIT_W+1)'(BCD_RADIX));
      co = 1'b1;
    end
    invalid = (a > DIGIT_W'(BCD_MAX_DIGIT)) || (b > DIGIT_W'(BCD_MAX_DIGIT));
  end

endmodule

// File: rtl/serial_bcd_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit per cycle, LSB first, through a
// single shared digit adder.
module serial_bcd_add_ctrl
  import serial_bcd_add_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state, state_nxt;
  logic [W-1:0]       a_q, b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic [DIGIT_W-1:0] da, db, ds;
  logic               dco, dinv;

  // Select the current operand digits.
  always_comb begin
    da   = '0;
    db   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        da = a_q[DIGIT_W*i +: DIGIT_W];
        db = b_q[DIGIT_W*i +: DIGIT_W];
      end
    end
    last = (idx == IDX_W'(DIGITS - 1));
  end

  bcd_digit_adder u_digit (
    .a       (da),
    .b       (db),
    .ci      (carry_q),
    .s       (ds),
    .co      (dco),
    .invalid (dinv)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) sum[DIGIT_W*i +: DIGIT_W] <= ds;
          end
          carry_q <= dco;
          err     <= err | dinv;
          idx     <= idx + IDX_W'(1);
          if (last) begin
            cout <= dco;
            idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
